// File: rtl/alu_pkg.sv
// Shared ALU definitions: op_sel encodings, flag bit positions and the
// state encoding of the iterative inc/dec unit.
package alu_pkg;

    localparam logic [1:0] OP_INC_A = 2'b00;
    localparam logic [1:0] OP_INC_B = 2'b01;
    localparam logic [1:0] OP_DEC_A = 2'b10;
    localparam logic [1:0] OP_DEC_B = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_step.sv
// Single +1/-1 step on an ANCHO-bit value, reporting unsigned wrap
// (carry or borrow) and signed overflow of that step.
module alu_step #(
    parameter int ANCHO = 4
) (
    input  logic [ANCHO-1:0] value,
    input  logic             dir,      // 0 = increment, 1 = decrement
    output logic [ANCHO-1:0] next,
    output logic             carry,
    output logic             ovf
);

    localparam logic [ANCHO-1:0] ALL_ONES = {ANCHO{1'b1}};
    localparam logic [ANCHO-1:0] MAX_POS  = {1'b0, {(ANCHO-1){1'b1}}};
    localparam logic [ANCHO-1:0] MIN_NEG  = {1'b1, {(ANCHO-1){1'b0}}};

    always_comb begin
        next  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        if (dir) begin
            next  = value - ANCHO'(1);
            carry = (value == '0);
            ovf   = (value == MIN_NEG);
        end else begin
            next  = value + ANCHO'(1);
            carry = (value == ALL_ONES);
            ovf   = (value == MAX_POS);
        end
    end

endmodule

// File: rtl/alu_incdec_iter.sv
// Iterative inc/dec unit: applies reps single steps to operand A or B,
// one per cycle, with a registered result and sticky C/V flags.
module alu_incdec_iter
    import alu_pkg::*;
#(
    parameter int ANCHO = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic [CNT_W-1:0] reps,
    output logic             busy,
    output logic             done,
    output logic [ANCHO-1:0] aluresult,
    output logic [3:0]       aluflags,
    output state_t           state_dbg
);

    // Handshake: start is sampled only while busy=0 (IDLE or DONE); a start
    // seen there is accepted at that edge. busy is high for exactly reps
    // cycles, then done pulses for one cycle with aluresult/aluflags valid.
    // start while busy=1 is dropped, never queued.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [ANCHO-1:0] result_q;
    logic             n_q, z_q, c_q, v_q;

    logic             accept;
    logic [ANCHO-1:0] operand;
    logic [ANCHO-1:0] step_next;
    logic             step_carry, step_ovf;

    assign accept  = start && (state_q != RUN);
    assign operand = op_sel[0] ? b : a;

    alu_step #(.ANCHO(ANCHO)) u_step (
        .value (result_q),
        .dir   (dir_q),
        .next  (step_next),
        .carry (step_carry),
        .ovf   (step_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (reps != '0) ? RUN : DONE;
                else       state_d = IDLE;
            end
            RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q <= operand;
                dir_q    <= op_sel[1];
                cnt_q    <= reps;
                n_q      <= operand[ANCHO-1];
                z_q      <= (operand == '0);
                c_q      <= 1'b0;
                v_q      <= 1'b0;
            end else if (state_q == RUN) begin
                result_q <= step_next;
                cnt_q    <= cnt_q - CNT_W'(1);
                n_q      <= step_next[ANCHO-1];
                z_q      <= (step_next == '0);
                c_q      <= c_q | step_carry;
                v_q      <= v_q | step_ovf;
            end
        end
    end

    always_comb begin
        aluflags        = '0;
        aluflags[FLG_N] = n_q;
        aluflags[FLG_Z] = z_q;
        aluflags[FLG_C] = c_q;
        aluflags[FLG_V] = v_q;
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign aluresult = result_q;
    assign state_dbg = state_q;

endmodule
